// File: rtl/karatsuba_seq_mult.sv
// Sequential one-level Karatsuba multiplier: one shared HxH multiplier is used three times per operand pair.
// Latency 4 cycles from accept to out_valid (5 when KARATSUBA_MULT_PIPE_EN adds a multiplier output register).
// Backpressure: Z and out_valid hold in DONE until out_ready; in_ready is high only in IDLE.
module karatsuba_seq_mult #(
    parameter int N = 82
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     X,
    input  logic [N-1:0]     Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   Z
);
    localparam int H = N / 2;

`ifdef KARATSUBA_MULT_PIPE_EN
    typedef enum logic [2:0] {IDLE, P0, P2, PD, DRAIN, SUM, DONE} state_t;
    // Registered multiplier: each product lands one state after it is issued.
    localparam state_t CAP_P0 = P2;
    localparam state_t CAP_P2 = PD;
    localparam state_t CAP_PD = DRAIN;
`else
    typedef enum logic [2:0] {IDLE, P0, P2, PD, SUM, DONE} state_t;
    localparam state_t CAP_P0 = P0;
    localparam state_t CAP_P2 = P2;
    localparam state_t CAP_PD = PD;
`endif

    state_t state_q, state_d;

    logic [N-1:0]   x_q, y_q;
    logic [N-1:0]   p0_q, p2_q, pd_q;
    logic [2*N-1:0] z_q, z_d;

    logic [H-1:0]   x1, x0, y1, y0, dx, dy;
    logic           sx, sy;
    logic [H-1:0]   mul_a, mul_b;
    logic [N-1:0]   mul_res, prod;
    logic [N+1:0]   sum_pp, mid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = P0;
            P0:      state_d = P2;
            P2:      state_d = PD;
`ifdef KARATSUBA_MULT_PIPE_EN
            PD:      state_d = DRAIN;
            DRAIN:   state_d = SUM;
`else
            PD:      state_d = SUM;
`endif
            SUM:     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign x1 = x_q[N-1:H];
    assign x0 = x_q[H-1:0];
    assign y1 = y_q[N-1:H];
    assign y0 = y_q[H-1:0];

    // Sign-magnitude differences keep the third product within the HxH multiplier.
    assign sx = (x1 >= x0);
    assign sy = (y1 >= y0);
    assign dx = sx ? (x1 - x0) : (x0 - x1);
    assign dy = sy ? (y1 - y0) : (y0 - y1);

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            P0: begin
                mul_a = x0;
                mul_b = y0;
            end
            P2: begin
                mul_a = x1;
                mul_b = y1;
            end
            PD: begin
                mul_a = dx;
                mul_b = dy;
            end
            default: ;
        endcase
    end

    assign mul_res = {{H{1'b0}}, mul_a} * {{H{1'b0}}, mul_b};

`ifdef KARATSUBA_MULT_PIPE_EN
    logic [N-1:0] mul_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_q <= '0;
        end else begin
            mul_q <= mul_res;
        end
    end

    assign prod = mul_q;
`else
    assign prod = mul_res;
`endif

    // (X1-X0)(Y1-Y0) is positive when the signs agree, so it is subtracted from p2+p0.
    assign sum_pp = {2'b00, p2_q} + {2'b00, p0_q};
    assign mid    = (sx == sy) ? (sum_pp - {2'b00, pd_q}) : (sum_pp + {2'b00, pd_q});
    assign z_d    = {p2_q, {N{1'b0}}}
                  + ({{(N-2){1'b0}}, mid} << H)
                  + {{N{1'b0}}, p0_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q  <= '0;
            y_q  <= '0;
            p0_q <= '0;
            p2_q <= '0;
            pd_q <= '0;
            z_q  <= '0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                x_q <= X;
                y_q <= Y;
            end
            if (state_q == CAP_P0) p0_q <= prod;
            if (state_q == CAP_P2) p2_q <= prod;
            if (state_q == CAP_PD) pd_q <= prod;
            if (state_q == SUM)    z_q  <= z_d;
        end
    end

    assign Z = z_q;

endmodule

// File: doc/karatsuba_seq_mult.md
KARATSUBA_SEQ_MULT -- requirements
Module: karatsuba_seq_mult

Interface
REQ-001 The block SHALL have parameter N, default 82, meaning unsigned operand width; it SHALL be even and at least 4.
REQ-002 The block SHALL have derived localparam H = N/2, meaning the half-word width of the single shared HxH multiplier.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning a synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the X/Y operand pair is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept operands.
REQ-007 The block SHALL have port X, input, N bits, meaning the unsigned multiplicand.
REQ-008 The block SHALL have port Y, input, N bits, meaning the unsigned multiplier.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning Z holds a valid product.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts Z.
REQ-011 The block SHALL have port Z, output, 2N bits, meaning the registered unsigned product X*Y.

Function
REQ-012 Accept SHALL occur on a rising edge with in_valid & in_ready; X and Y SHALL be captured into internal registers on that edge.
REQ-013 One-level Karatsuba SHALL be used: X = X1*2^H + X0 and Y = Y1*2^H + Y0, with p0 = X0*Y0, p2 = X1*Y1 and pd = |X1-X0| * |Y1-Y0|.
REQ-014 The difference signs sx = (X1>=X0) and sy = (Y1>=Y0) SHALL be kept in sign-magnitude form; both magnitudes fit in H bits.
REQ-015 The middle term SHALL be mid = p2 + p0 - pd when sx==sy, and p2 + p0 + pd otherwise; mid is nonnegative and at most N+2 bits wide.
REQ-016 The result SHALL be Z = p2*2^N + mid*2^H + p0, computed without truncation into 2N bits; it SHALL equal X*Y for all inputs.
REQ-017 Exactly one HxH multiplier instance SHALL exist and be time-multiplexed over p0, p2 and pd, in that order.
REQ-018 The state machine SHALL have states IDLE, P0, P2, PD, SUM and DONE (plus DRAIN when REQ-029 applies).
REQ-019 Transitions SHALL be IDLE->P0 on accept, P0->P2->PD->SUM unconditionally, SUM->DONE, and DONE->IDLE on out_valid & out_ready.
REQ-020 in_ready SHALL be 1 only in IDLE; in_valid SHALL be ignored in every other state, with no effect on captured operands.
REQ-021 Z SHALL be registered in SUM; out_valid SHALL be 1 only in DONE.
REQ-022 Latency without the macro SHALL be 4 cycles: an accept on edge k SHALL give out_valid=1 after edge k+4.
REQ-023 While in DONE with out_ready=0, Z and out_valid SHALL hold stable.
REQ-024 No accept SHALL occur in the cycle the output is consumed; in_ready SHALL rise in the cycle after the output handshake, so the minimum accept-to-accept interval is 6 cycles.
REQ-025 Z SHALL retain the last product after the handshake, until the next SUM.

Reset
REQ-026 When rst=1 at a rising edge, state SHALL become IDLE, out_valid SHALL become 0, in_ready SHALL be 1 in the following cycle, and Z and all product registers SHALL clear to 0.
REQ-027 Reset SHALL take priority over every handshake; reset in any state, mid-operation included, SHALL abort the operation with no output produced.
REQ-028 Operands presented during the reset cycle SHALL NOT be accepted.

Configuration
REQ-029 Macro KARATSUBA_MULT_PIPE_EN, when defined, SHALL add an output register on the shared multiplier and insert state DRAIN between PD and SUM.
REQ-030 With the macro defined, each product SHALL be captured one cycle after its issue state, and latency SHALL be 5 cycles (accept edge k gives out_valid after edge k+5).
REQ-031 Without the macro, the multiplier SHALL be combinational, products SHALL be captured in their issue state, and latency SHALL be 4 cycles; results SHALL be bit-identical in both builds.

Verification
REQ-032 The bench SHALL check reset: rst=1 for 2 cycles -> out_valid=0, in_ready=1, Z=0.
REQ-033 The bench SHALL check a basic product: N=82, X=3, Y=5 -> Z=15, with out_valid after exactly 4 edges (5 with the macro).
REQ-034 The bench SHALL check the maximum case: N=82, X=Y=2^82-1 -> Z=2^164-2^83+1, with no overflow.
REQ-035 The bench SHALL check mixed difference signs: N=8, X=0xF1, Y=0x1F (sx=1, sy=0) -> Z=0x1D2F; then X=0x1F, Y=0x1F -> Z=0x03C1.
REQ-036 The bench SHALL check backpressure: out_ready=0 for 10 cycles in DONE -> Z and out_valid stable, in_ready=0, and in_valid pulses ignored; then out_ready=1 -> IDLE on the next edge.
REQ-037 The bench SHALL check reset mid-operation: rst=1 in P2 -> IDLE next edge, out_valid never asserts for the aborted operation, and the next operands X=7, Y=9 give Z=63.
